// File: rtl/ls_word_serializer.sv
// -----------------------------------------------------------------------------
// ls_word_serializer
//
// Parallel-in, serial-out word transmitter. A WIDTH-bit word is captured from a
// register-style parallel bus on a load request and shifted out one bit per
// clock. A 165-style clock inhibit freezes shifting, and a serial fill bit is
// shifted into the vacated end. busy/done let downstream logic frame the word.
//
// Build option:
//   LS_SERIALIZER_LSB_FIRST_EN  - when defined, the word leaves LSB first
//                                 (shift right, q taken from bit 0). When
//                                 undefined, the word leaves MSB first.
//
// Parameters:
//   WIDTH    word length in bits, 2..16
//
// Ports:
//   clk      in   1      rising-edge clock
//   clr      in   1      asynchronous active-high clear, dominant over all
//   d        in   WIDTH  parallel word to transmit
//   load     in   1      synchronous load request
//   clk_inh  in   1      clock inhibit; freezes shifting while high
//   ser      in   1      serial fill bit shifted into the vacated end
//   q        out  1      serial data out (combinational from the shift register)
//   q_       out  1      complement of q
//   busy     out  1      high while a word is being shifted
//   done     out  1      one-cycle pulse after the last bit is shifted out
// -----------------------------------------------------------------------------
module ls_word_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             clk_inh,
  input  logic             ser,
  output logic             q,
  output logic             q_,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;

  // One shift step with the fill bit entering the vacated end.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] cur,
                                                  input logic             fill);
`ifdef LS_SERIALIZER_LSB_FIRST_EN
    return {fill, cur[WIDTH-1:1]};
`else
    return {cur[WIDTH-2:0], fill};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // State register. clr clears everything immediately, so an aborted word
  // never produces a done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. done_d defaults low so done is a single-cycle pulse that
  // is only raised on the edge that shifts out the final bit.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // ser and clk_inh have no effect while idle; shreg keeps the fill
        // history of the last frame so idle q stays deterministic.
        if (load) begin
          shreg_d = d;
          cnt_d   = CNT_LAST;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (load) begin
          // Restart wins over inhibit and over the final-bit edge.
          shreg_d = d;
          cnt_d   = CNT_LAST;
        end else if (!clk_inh) begin
          shreg_d = shift_step(shreg_q, ser);
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: q is the bit currently at the outgoing end of the register.
`ifdef LS_SERIALIZER_LSB_FIRST_EN
  assign q = shreg_q[0];
`else
  assign q = shreg_q[WIDTH-1];
`endif
  assign q_   = ~q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: doc/ls_word_serializer.md
Name: ls_word_serializer

Overview:
- Parallel-in, serial-out word transmitter, the counterpart to the quad D register.
- Captures a WIDTH-bit word from a register-style parallel bus.
- Shifts the word out one bit per clock with a 165-style clock inhibit and serial fill input.
- Provides busy/done status so a downstream receiver or control logic can frame the word.

Parameters:
WIDTH, 4, word length in bits; legal range 2..16.

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-high reset (clear)
d  input  WIDTH  parallel word to transmit
load  input  1  synchronous load request, sampled at rising clk
clk_inh  input  1  clock inhibit; when 1, shifting is frozen
ser  input  1  serial fill bit shifted into the vacated end
q  output  1  serial data out
q_  output  1  complement of q; always equals ~q
busy  output  1  1 while a word is being shifted
done  output  1  one-cycle pulse after the last bit of a word is shifted out

Behaviour:
- clr=1, asynchronous and dominant over all other inputs: shreg=0, cnt=0, state=IDLE, busy=0, done=0, q=0, q_=1. Applies immediately, including mid-word; the aborted word produces no done.
- State encoding: IDLE and SHIFT; cnt is a down-counter of width clog2(WIDTH).
- Outputs: q = shreg[WIDTH-1], combinational from shreg; q_ = ~q; busy = (state==SHIFT), registered.
- IDLE:
  - load=1 at an edge: shreg<=d, cnt<=WIDTH-1, state<=SHIFT.
  - Otherwise shreg holds; ser and clk_inh are ignored.
- SHIFT, priority order at each edge:
  1. load=1: restart. shreg<=d, cnt<=WIDTH-1, stay in SHIFT, done<=0. This also applies on the final-bit edge: load wins and done is not pulsed.
  2. clk_inh=1: shreg, cnt and state all hold; done<=0.
  3. Otherwise shift: shreg<={shreg[WIDTH-2:0], ser}.
     - If cnt!=0: cnt<=cnt-1.
     - If cnt==0: state<=IDLE, done<=1 for exactly one cycle.
- Latency and timing:
  - The first bit, d[WIDTH-1], is valid on q in the cycle after the load edge.
  - Each subsequent bit appears after each non-inhibited edge.
  - A full word with no inhibit occupies WIDTH cycles of busy=1. done is high in the cycle after busy falls.
- After the frame, shreg contains the last WIDTH ser bits and q shows the newest MSB. Idle-state q is therefore deterministic from ser history.
- done is cleared on every edge where the final-shift condition is not met.
- load during inhibit is honoured, because load has priority over clk_inh.
- X on d is captured as X. X on load or clk_inh is not required to be handled.

Optional Feature:
LS_SERIALIZER_LSB_FIRST_EN
- Defined: shift direction reverses. shreg<={ser, shreg[WIDTH-1:1]}, q=shreg[0], and the word goes out LSB first. All timing, done and busy behaviour is unchanged.
- Undefined: MSB-first as described in Behaviour.

Test Plan:
- Reset: clr=1 async mid-cycle, then clr=0 -> q=0, q_=1, busy=0, done=0 immediately, with no clock edge required.
- Basic frame: WIDTH=4, d=1010, load one cycle, clk_inh=0, ser=0.
  - q over the next 4 cycles = 1,0,1,0 with busy=1.
  - done=1 exactly in cycle 5, then busy=0 and q=0.
- Inhibit: load 0101, assert clk_inh for 3 cycles after the 2nd bit.
  - q holds 1 (bit 2) for 4 cycles total, busy stays 1, then the remaining bits 0,1 follow.
  - done pulses once.
- Restart: load 1111, after 2 bits load 0000.
  - q=0 for the next 4 cycles.
  - No done before the second frame ends; exactly one done pulse total.
- Reset mid-word: load 1010, assert clr after 1 bit -> q=0, busy=0, and no done ever pulses for that word.
- Fill and LSB option: ser=1 through the frame of d=0000 -> q=1 in idle afterwards. With LS_SERIALIZER_LSB_FIRST_EN, d=0001 -> q sequence 1,0,0,0.
